// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and helpers for the register-bus arbiter.
// Holds the sequencer state encoding and the one-hot decode used for register selects.
package reg_bus_arbiter_pkg;

  localparam int unsigned MaxRegs = 256;
  localparam int unsigned IdxBits = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    RD      = 3'd2,
    WR_WAIT = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Wide one-hot decode; callers truncate to their register count with a sized cast.
  function automatic logic [MaxRegs-1:0] onehot(input logic [IdxBits-1:0] idx);
    onehot = MaxRegs'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_priority_pick.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
// Purely combinational; returns the one-hot pick and its binary index.
module rr_priority_pick #(
  parameter int unsigned NrOfReq = 2,
  parameter int unsigned IdxW    = (NrOfReq > 1) ? $clog2(NrOfReq) : 1
) (
  input  logic [NrOfReq-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NrOfReq-1:0] pick_c,
  output logic [IdxW-1:0]    pick_idx_c,
  output logic               any_c
);

  logic [IdxW-1:0] cand;

  always_comb begin
    pick_c     = '0;
    pick_idx_c = '0;
    any_c      = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < NrOfReq; i++) begin
      cand = IdxW'((32'(ptr) + i) % NrOfReq);
      if (!any_c && req[cand]) begin
        any_c        = 1'b1;
        pick_c[cand] = 1'b1;
        pick_idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin sequencer sharing one bank of tristate-output registers between requesters.
// Drives one register select at a time, strobes loads only on Tick, returns data with ack.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int unsigned NrOfReq  = 2,
  parameter int unsigned NrOfRegs = 8,
  parameter int unsigned AddrBits = 3,
  parameter int unsigned NrOfBits = 32
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Tick,
  input  logic [NrOfReq-1:0]           req,
  input  logic [NrOfReq-1:0]           we,
  input  logic [NrOfReq*AddrBits-1:0]  addr,
  input  logic [NrOfReq*NrOfBits-1:0]  wdata,
  output logic [NrOfReq-1:0]           gnt,
  output logic [NrOfReq-1:0]           ack,
  output logic                         err,
  output logic [NrOfBits-1:0]          rdata,
  output logic [NrOfRegs-1:0]          reg_cs,
  output logic [NrOfRegs-1:0]          reg_ce,
  output logic [NrOfBits-1:0]          reg_d,
  input  logic [NrOfBits-1:0]          bus_q,
  output logic                         busy
);

  localparam int unsigned IdxW = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       sel_q, sel_d;
  logic                  we_q, we_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic [NrOfBits-1:0]   wdata_q, wdata_d;
  logic                  bad_q, bad_d;

  logic [NrOfReq-1:0]    gnt_d, ack_d;
  logic                  err_d, busy_d;
  logic [NrOfBits-1:0]   rdata_d, reg_d_d;
  logic [NrOfRegs-1:0]   cs_d, ce_d;
  logic [NrOfRegs-1:0]   addr_sel_c;

  logic [NrOfReq-1:0]    pick_c;
  logic [IdxW-1:0]       pick_idx_c;
  logic                  any_c;

  rr_priority_pick #(
    .NrOfReq (NrOfReq),
    .IdxW    (IdxW)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .pick_c     (pick_c),
    .pick_idx_c (pick_idx_c),
    .any_c      (any_c)
  );

  assign addr_sel_c = NrOfRegs'(onehot(IdxBits'(addr_q)));

  // State and registered outputs; reset aborts any transaction with no ack or strobe.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      gnt     <= '0;
      ack     <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      reg_cs  <= '0;
      reg_ce  <= '0;
      reg_d   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
      gnt     <= gnt_d;
      ack     <= ack_d;
      err     <= err_d;
      rdata   <= rdata_d;
      reg_cs  <= cs_d;
      reg_ce  <= ce_d;
      reg_d   <= reg_d_d;
      busy    <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    gnt_d   = gnt;
    ack_d   = '0;
    err_d   = 1'b0;
    rdata_d = rdata;
    cs_d    = reg_cs;
    ce_d    = reg_ce;
    reg_d_d = reg_d;

    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          sel_d = pick_idx_c;
          for (int unsigned i = 0; i < NrOfReq; i++) begin
            if (pick_c[i]) begin
              we_d    = we[i];
              addr_d  = addr[i*AddrBits +: AddrBits];
              wdata_d = wdata[i*NrOfBits +: NrOfBits];
            end
          end
          gnt_d   = pick_c;
          state_d = GRANT;
        end
      end

      GRANT: begin
        bad_d = (32'(addr_q) >= NrOfRegs);
        if (32'(addr_q) >= NrOfRegs) begin
          state_d = DONE;
        end else begin
          cs_d    = addr_sel_c;
          reg_d_d = wdata_q;
          if (we_q) begin
            ce_d    = addr_sel_c;
            state_d = WR_WAIT;
          end else begin
            state_d = RD;
          end
        end
      end

      RD: begin
        rdata_d = bus_q;
        cs_d    = '0;
        state_d = DONE;
      end

      // ce stays high until a Tick cycle has passed, giving exactly one load.
      WR_WAIT: begin
        if (Tick) begin
          ce_d    = '0;
          cs_d    = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        ack_d   = gnt;
        err_d   = bad_q;
        gnt_d   = '0;
        cs_d    = '0;
        ce_d    = '0;
        bad_d   = 1'b0;
        ptr_d   = (sel_q == IdxW'(NrOfReq - 1)) ? '0 : IdxW'(sel_q + 1'b1);
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        cs_d    = '0;
        ce_d    = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
